acc_dummy_accel: RTL

ACC_DUMMY_ACCEL -- requirements
Module: acc_dummy_accel

---
 rtl/acc_dummy_if.sv | 28 ++
 rtl/acc_dummy_accel.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/acc_dummy_if.sv
// acc_dummy_if: request/response handshake bundle of the dummy accelerator.
// master = offloading core side, slave = accelerator side.
interface acc_dummy_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRs     = 3,
    parameter int unsigned IdWidth   = 5
);
    logic                       req_valid_i;
    logic                       req_ready_o;
    logic [31:0]                req_instr_i;
    logic [NumRs*DataWidth-1:0] req_rs_i;
    logic [IdWidth-1:0]         req_id_i;
    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic [DataWidth-1:0]       rsp_data_o;
    logic [IdWidth-1:0]         rsp_id_o;
    logic                       rsp_error_o;

    modport master (
        output req_valid_i, req_instr_i, req_rs_i, req_id_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_instr_i, req_rs_i, req_id_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_error_o
    );
endinterface

// File: rtl/acc_dummy_accel.sv
// acc_dummy_accel: add/sub/xor/add3 offload unit, fixed latency, FIFO responses.
// ACC_DUMMY_ERR_RSP_EN: illegal requests return an error response instead of being dropped.
module acc_dummy_accel #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRs     = 3,
    parameter int unsigned AccAddr   = 0,
    parameter int unsigned Latency   = 2,
    parameter int unsigned Depth     = 4,
    parameter int unsigned IdWidth   = 5
) (
    input logic        clk_i,
    input logic        rst_ni,
    acc_dummy_if.slave bus
);
    localparam int unsigned     PtrW     = $clog2(Depth);
    localparam int unsigned     OccW     = $clog2(Depth + 1);
    localparam logic [OccW-1:0] DepthCnt = OccW'(Depth);
    localparam logic [4:0]      AccNum   = 5'(AccAddr);

    logic [4:0]             acc_num;
    logic                   wb;
    logic [2:0]             op;
    logic [3*DataWidth-1:0] rs_pad;
    logic [DataWidth-1:0]   rs0, rs1, rs2;
    logic [DataWidth-1:0]   result;
    logic                   op_ok;
    logic                   legal;
    logic                   accept;
    logic                   ins;
    logic [DataWidth-1:0]   ins_data;
    logic                   unused_bits;

    assign acc_num = bus.req_instr_i[31:27];
    assign wb      = bus.req_instr_i[13];
    assign op      = bus.req_instr_i[2:0];
    assign unused_bits = ^{bus.req_instr_i[26:14], bus.req_instr_i[12:3]};

    // rs2 reads as zero when only two operands exist
    assign rs_pad = (3*DataWidth)'(bus.req_rs_i);
    assign rs0    = rs_pad[DataWidth-1:0];
    assign rs1    = rs_pad[2*DataWidth-1:DataWidth];
    assign rs2    = rs_pad[3*DataWidth-1:2*DataWidth];

    always_comb begin
        op_ok  = 1'b1;
        result = '0;
        case (op)
            3'd0: result = rs0 + rs1;
            3'd1: result = rs0 - rs1;
            3'd2: result = rs0 ^ rs1;
            3'd3: begin
                result = rs0 + rs1 + rs2;
                op_ok  = (NumRs > 2);
            end
            default: op_ok = 1'b0;
        endcase
    end

    assign legal = op_ok && (acc_num == AccNum);

    logic [OccW-1:0] occ;
    logic            pop;
    logic            rsp_vld;

    assign bus.req_ready_o = (occ < DepthCnt);
    assign accept = bus.req_valid_i && bus.req_ready_o;
    assign pop    = rsp_vld && bus.rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ <= '0;
        end else begin
            case ({ins, pop})
                2'b10:   occ <= occ + OccW'(1);
                2'b01:   occ <= occ - OccW'(1);
                default: occ <= occ;
            endcase
        end
    end

    logic [Latency-1:0]   pipe_vld;
    logic [DataWidth-1:0] pipe_data [Latency];
    logic [IdWidth-1:0]   pipe_id   [Latency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            for (int k = 0; k < int'(Latency); k++) begin
                pipe_data[k] <= '0;
                pipe_id[k]   <= '0;
            end
        end else begin
            pipe_vld[0]  <= ins;
            pipe_data[0] <= ins_data;
            pipe_id[0]   <= bus.req_id_i;
            for (int k = 1; k < int'(Latency); k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_data[k] <= pipe_data[k-1];
                pipe_id[k]   <= pipe_id[k-1];
            end
        end
    end

    // occupancy covers in-flight entries, so the buffer always has room here
    logic                 push;
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [OccW-1:0]      buf_cnt;
    logic [DataWidth-1:0] mem_data [Depth];
    logic [IdWidth-1:0]   mem_id   [Depth];

    assign push = pipe_vld[Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_cnt <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_data[i] <= '0;
                mem_id[i]   <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= pipe_data[Latency-1];
                mem_id[wr_ptr]   <= pipe_id[Latency-1];
                wr_ptr           <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + OccW'(1);
                2'b01:   buf_cnt <= buf_cnt - OccW'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    assign rsp_vld         = (buf_cnt != '0);
    assign bus.rsp_valid_o = rsp_vld;
    assign bus.rsp_data_o  = rsp_vld ? mem_data[rd_ptr] : '0;
    assign bus.rsp_id_o    = rsp_vld ? mem_id[rd_ptr] : '0;

`ifdef ACC_DUMMY_ERR_RSP_EN
    logic               ins_err;
    logic [Latency-1:0] pipe_err;
    logic [Depth-1:0]   mem_err;

    assign ins      = accept && (!legal || wb);
    assign ins_data = legal ? result : '0;
    assign ins_err  = !legal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_err <= '0;
            mem_err  <= '0;
        end else begin
            pipe_err[0] <= ins_err;
            for (int k = 1; k < int'(Latency); k++) begin
                pipe_err[k] <= pipe_err[k-1];
            end
            if (push) begin
                mem_err[wr_ptr] <= pipe_err[Latency-1];
            end
        end
    end

    assign bus.rsp_error_o = rsp_vld && mem_err[rd_ptr];
`else
    assign ins      = accept && legal && wb;
    assign ins_data = result;

    assign bus.rsp_error_o = 1'b0;
`endif

endmodule
